// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end: imem req/ack fetcher feeding a prefetch FIFO
// Presents the FIFO head as the IF/ID producer; one fetch outstanding at a time.
module if_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] PC_o,
  output logic [31:0] Instruction_o,
  output logic        valid_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_req;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && !stall_i && !branch_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // rst_i gating keeps the request low while reset is held even though IDLE would otherwise fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_full && !branch_i && rst_i) begin
          w_req       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          w_push      = !branch_i;
          w_state_nxt = S_IDLE;
        end else if (branch_i) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (branch_i) begin
        r_fetch_pc <= branch_target_i;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_req) begin
        r_req_addr <= r_fetch_pc;
      end
    end
  end

  // While a fetch is outstanding the address must not follow a redirect.
  assign imem_req_o  = w_req;
  assign imem_addr_o = (r_state == S_IDLE) ? r_fetch_pc : r_req_addr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (branch_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_req_addr;
      r_ins_mem[r_wr_ptr] <= imem_data_i;
    end
  end

  assign valid_o       = !w_empty;
  assign PC_o          = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr];
  assign Instruction_o = w_empty ? 32'h0 : r_ins_mem[r_rd_ptr];

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized bench for if_fetch_unit against a queue-based fetch model
// Directed phases pin the model with literal expectations; a random phase exercises stall/branch/latency.
module tb_if_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] PC_o;
  logic [31:0] Instruction_o;
  logic        valid_o;

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .stall_i(stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .PC_o(PC_o), .Instruction_o(Instruction_o), .valid_o(valid_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: FIFO contents as a queue of {pc, instr}, plus the single outstanding fetch.
  logic [63:0] m_q[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  bit          m_pending = 0;
  bit          m_drop = 0;
  logic [31:0] m_pend_addr = '0;

  // Memory responder.
  bit          rsp_busy = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hXXXX_XXXX;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc  = RESET_PC;
    m_pending   = 0;
    m_drop      = 0;
    m_pend_addr = RESET_PC;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then advance model and responder.
  task automatic cycle(input bit rst, input bit stall, input bit br, input logic [31:0] tgt);
    bit          ack;
    bit          exp_req;
    bit          pop;
    bit          push;
    logic [31:0] dat;
    logic [63:0] hd;
    ack = 0;
    dat = $urandom;
    if (rsp_busy) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        ack      = 1;
        dat      = mem_word(rsp_addr);
        rsp_busy = 0;
      end
    end
    rst_i = rst; stall_i = stall; branch_i = br; branch_target_i = tgt;
    imem_ack_i = ack; imem_data_i = dat;
    #1;
    if (!rst) begin
      model_reset();
      check32("rst_req",   {31'b0, imem_req_o}, 32'h0);
      check32("rst_addr",  imem_addr_o, RESET_PC);
      check32("rst_valid", {31'b0, valid_o}, 32'h0);
      check32("rst_pc",    PC_o, 32'h0);
      check32("rst_instr", Instruction_o, 32'h0);
    end else begin
      exp_req = !m_pending && (m_q.size() < DEPTH) && !br;
      hd = (m_q.size() > 0) ? m_q[0] : 64'h0;
      check32("req", {31'b0, imem_req_o}, {31'b0, exp_req});
      if (exp_req) check32("req_addr", imem_addr_o, m_fetch_pc);
      else if (m_pending) check32("hold_addr", imem_addr_o, m_pend_addr);
      check32("valid", {31'b0, valid_o}, {31'b0, m_q.size() > 0});
      check32("pc",    PC_o, hd[63:32]);
      check32("instr", Instruction_o, hd[31:0]);
      if (valid_o && !stall && !br) pop_log.push_back(PC_o);

      pop  = (m_q.size() > 0) && !stall && !br;
      push = m_pending && !m_drop && ack && !br;
      if (br) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({m_pend_addr, dat});
      end
      if (m_pending && ack) begin
        m_pending = 0;
        m_drop    = 0;
      end else if (m_pending && br) begin
        m_drop = 1;
      end
      if (exp_req) begin
        m_pending   = 1;
        m_pend_addr = m_fetch_pc;
      end
      if (br) m_fetch_pc = tgt;
      else if (push) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (imem_req_o) begin
      req_log.push_back(imem_addr_o);
      rsp_busy = 1;
      rsp_cnt  = $urandom_range(lat_lo, lat_hi);
      rsp_addr = imem_addr_o;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    repeat (5) cycle(0, 0, 0, 32'h0);
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    logic [31:0] t;
    @(negedge clk_i);
    do_reset();

    // Streaming with 1-cycle latency, no stall.
    lat_lo = 1; lat_hi = 1;
    repeat (30) cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) check32("p1_pop_pc", qat(pop_log, i), 32'(i * 4));
    check32("p1_req0", qat(req_log, 0), RESET_PC);

    // Stall fills the FIFO; release drains in order.
    do_reset();
    repeat (20) cycle(1, 1, 0, 32'h0);
    check32("p2_req_count", 32'(req_log.size()), 32'd4);
    check32("p2_valid", {31'b0, valid_o}, 32'h1);
    check32("p2_head_pc", PC_o, 32'h0);
    check32("p2_head_instr", Instruction_o, mem_word(32'h0));
    pop_log.delete();
    repeat (8) cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) check32("p2_pop_pc", qat(pop_log, i), 32'(i * 4));

    // Branch while waiting; the in-flight response is dropped.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 1, 32'h100);
    repeat (3) cycle(1, 0, 0, 32'h0);
    check32("p3_req_count", 32'(req_log.size()), 32'd2);
    check32("p3_redirect_addr", qat(req_log, 1), 32'h100);
    repeat (2) cycle(1, 0, 0, 32'h0);
    check32("p3_valid_low", {31'b0, valid_o}, 32'h0);
    cycle(1, 1, 0, 32'h0);
    check32("p3_valid_high", {31'b0, valid_o}, 32'h1);
    check32("p3_head_pc", PC_o, 32'h100);
    check32("p3_head_instr", Instruction_o, mem_word(32'h100));

    // Branch coincides with ack.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 1, 32'h40);
    check32("p4_valid_low", {31'b0, valid_o}, 32'h0);
    cycle(1, 0, 0, 32'h0);
    check32("p4_redirect_addr", qat(req_log, 1), 32'h40);

    // Reset during a fetch, stale ack right after release.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    cycle(1, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    check32("p5_req_after_rst", qat(req_log, 1), RESET_PC);
    check32("p5_valid_low", {31'b0, valid_o}, 32'h0);
    repeat (2) cycle(1, 1, 0, 32'h0);
    check32("p5_still_empty", {31'b0, valid_o}, 32'h0);
    repeat (3) cycle(1, 1, 0, 32'h0);

    // Fetch address wraps past the top of memory.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    cycle(1, 0, 1, 32'hFFFF_FFFC);
    repeat (6) cycle(1, 0, 0, 32'h0);
    check32("p6_top_addr", qat(req_log, 0), 32'hFFFF_FFFC);
    check32("p6_wrap_addr", qat(req_log, 1), 32'h0000_0000);

    // Random mix of stall, redirect, latency and occasional reset.
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      t = $urandom;
      t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
      cycle(1, $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
